// File: rtl/noc_ni_packetizer_if.sv
// Injection-port bundle: IP command/payload handshakes, NoC flit output and per-VC credits.
interface noc_ni_packetizer_if #(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned VC_NUM       = 4,
    parameter int unsigned VC_DEPTH     = 16,
    parameter int unsigned PRIO_WIDTH   = 2,
    parameter int unsigned PKT_ID_WIDTH = 8,
    parameter int unsigned LEN_WIDTH    = 4
);
    localparam int unsigned CW = $clog2(VC_DEPTH + 1);

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [PRIO_WIDTH-1:0]    cmd_prio;
    logic [LEN_WIDTH-1:0]     cmd_len;
    logic                     dat_valid;
    logic                     dat_ready;
    logic [DATA_WIDTH-1:0]    dat_data;
    logic                     flit_valid;
    logic [DATA_WIDTH-1:0]    flit_data;
    logic [VC_NUM-1:0]        flit_vc_id;
    logic [PRIO_WIDTH-1:0]    flit_prio;
    logic [PKT_ID_WIDTH-1:0]  flit_pkt_id;
    logic                     flit_tail;
    logic [VC_NUM-1:0]        credit_return;
    logic [VC_NUM*CW-1:0]     credit_cnt;

    // Packetizer side
    modport slave (
        input  cmd_valid, cmd_prio, cmd_len, dat_valid, dat_data, credit_return,
        output cmd_ready, dat_ready, flit_valid, flit_data, flit_vc_id, flit_prio,
        output flit_pkt_id, flit_tail, credit_cnt
    );

    // IP / NoC side
    modport master (
        output cmd_valid, cmd_prio, cmd_len, dat_valid, dat_data, credit_return,
        input  cmd_ready, dat_ready, flit_valid, flit_data, flit_vc_id, flit_prio,
        input  flit_pkt_id, flit_tail, credit_cnt
    );
endinterface

// File: rtl/noc_ni_packetizer.sv
// NoC network-interface injection stage: turns (prio, len) commands plus payload beats
// into wormhole flits on a prio-selected VC, gated by per-VC downstream credits.
module noc_ni_packetizer #(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned VC_NUM       = 4,
    parameter int unsigned VC_DEPTH     = 16,
    parameter int unsigned PRIO_WIDTH   = 2,
    parameter int unsigned PKT_ID_WIDTH = 8,
    parameter int unsigned LEN_WIDTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    noc_ni_packetizer_if.slave bus,
    output logic               busy,
    output logic               err_credit
);
    localparam int unsigned CW  = $clog2(VC_DEPTH + 1);
    localparam int unsigned VIW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PRIO_WIDTH-1:0]   prio_q, prio_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    beat_q, beat_d;
    logic [VIW-1:0]          vc_q, vc_d;
    logic [PKT_ID_WIDTH-1:0] pkt_id_q, pkt_id_d;
    logic [CW-1:0]           credit_q [VC_NUM];
    logic [CW-1:0]           credit_d [VC_NUM];
    logic                    err_q, err_d;

    logic                    flit_valid_q, flit_valid_d;
    logic [DATA_WIDTH-1:0]   flit_data_q, flit_data_d;
    logic [VC_NUM-1:0]       flit_vc_q, flit_vc_d;
    logic [PRIO_WIDTH-1:0]   flit_prio_q, flit_prio_d;
    logic [PKT_ID_WIDTH-1:0] flit_pkt_id_q, flit_pkt_id_d;
    logic                    flit_tail_q, flit_tail_d;

    logic cmd_hs, dat_hs, tail_beat;

    // Ready is a decode of current state and the selected VC's credit.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.dat_ready = (state_q == SEND) && (credit_q[vc_q] != '0);
    assign cmd_hs        = bus.cmd_valid & bus.cmd_ready;
    assign dat_hs        = bus.dat_valid & bus.dat_ready;
    assign tail_beat     = (beat_q == len_q);

    // Packet sequencing and flit formation
    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        len_d         = len_q;
        vc_d          = vc_q;
        beat_d        = beat_q;
        pkt_id_d      = pkt_id_q;
        flit_valid_d  = 1'b0;
        flit_data_d   = flit_data_q;
        flit_vc_d     = flit_vc_q;
        flit_prio_d   = flit_prio_q;
        flit_pkt_id_d = flit_pkt_id_q;
        flit_tail_d   = flit_tail_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    state_d = SEND;
                    prio_d  = bus.cmd_prio;
                    len_d   = bus.cmd_len;
                    vc_d    = VIW'(32'(bus.cmd_prio) % VC_NUM);
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (dat_hs) begin
                    flit_valid_d  = 1'b1;
                    flit_data_d   = bus.dat_data;
                    flit_vc_d     = VC_NUM'(1) << vc_q;
                    flit_prio_d   = prio_q;
                    flit_pkt_id_d = pkt_id_q;
                    flit_tail_d   = tail_beat;
                    beat_d        = beat_q + LEN_WIDTH'(1);
                    if (tail_beat) begin
                        state_d  = IDLE;
                        pkt_id_d = pkt_id_q + PKT_ID_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-VC credits: a send and a return in the same cycle cancel; overflow saturates and flags.
    always_comb begin
        err_d = err_q;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            credit_d[v] = credit_q[v];
            if (dat_hs && (vc_q == VIW'(v)) && !bus.credit_return[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (!(dat_hs && (vc_q == VIW'(v))) && bus.credit_return[v]) begin
                if (credit_q[v] == CW'(VC_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prio_q        <= '0;
            len_q         <= '0;
            vc_q          <= '0;
            beat_q        <= '0;
            pkt_id_q      <= '0;
            err_q         <= 1'b0;
            flit_valid_q  <= 1'b0;
            flit_data_q   <= '0;
            flit_vc_q     <= '0;
            flit_prio_q   <= '0;
            flit_pkt_id_q <= '0;
            flit_tail_q   <= 1'b0;
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                credit_q[v] <= CW'(VC_DEPTH);
            end
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            len_q         <= len_d;
            vc_q          <= vc_d;
            beat_q        <= beat_d;
            pkt_id_q      <= pkt_id_d;
            err_q         <= err_d;
            flit_valid_q  <= flit_valid_d;
            flit_data_q   <= flit_data_d;
            flit_vc_q     <= flit_vc_d;
            flit_prio_q   <= flit_prio_d;
            flit_pkt_id_q <= flit_pkt_id_d;
            flit_tail_q   <= flit_tail_d;
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    for (genvar g = 0; g < VC_NUM; g++) begin : g_credit_out
        assign bus.credit_cnt[g*CW +: CW] = credit_q[g];
    end

    assign bus.flit_valid  = flit_valid_q;
    assign bus.flit_data   = flit_data_q;
    assign bus.flit_vc_id  = flit_vc_q;
    assign bus.flit_prio   = flit_prio_q;
    assign bus.flit_pkt_id = flit_pkt_id_q;
    assign bus.flit_tail   = flit_tail_q;
    assign busy            = (state_q == SEND);
    assign err_credit      = err_q;
endmodule

// File: tb/tb_noc_ni_packetizer.sv
// Directed bench for noc_ni_packetizer: vector table for the basic packet flows plus
// hand sequences for credit starvation, credit overflow, pkt_id wrap and mid-packet reset.
module tb_noc_ni_packetizer;
    localparam int unsigned CW    = 5;
    localparam int unsigned NVEC  = 13;

    logic clk;
    logic rst_n;
    logic busy;
    logic err_credit;

    int n_checks = 0;
    int n_errors = 0;

    noc_ni_packetizer_if bus ();

    noc_ni_packetizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .err_credit (err_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned rst, cv, prio, len, dv, d, cr;
        int unsigned e_cr, e_dr, e_fv, e_d, e_vc, e_id, e_tail, e_prio;
    } vec_t;

    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] cred(input int v);
        return bus.credit_cnt[v*CW +: CW];
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid     = 1'b0;
        bus.cmd_prio      = '0;
        bus.cmd_len       = '0;
        bus.dat_valid     = 1'b0;
        bus.dat_data      = '0;
        bus.credit_return = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_cmd(input int unsigned p, input int unsigned l, output bit ok);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_prio  = 2'(p);
        bus.cmd_len   = 4'(l);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (bus.cmd_ready) begin
                ok = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic do_beat(input int unsigned d, input logic [3:0] cr, output bit ok);
        @(negedge clk);
        bus.dat_valid = 1'b1;
        bus.dat_data  = 512'(d);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (bus.dat_ready) begin
                bus.credit_return = cr;
                ok = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1;
        bus.dat_valid     = 1'b0;
        bus.credit_return = '0;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vec[i].rst != 0) do_reset();
            @(negedge clk);
            bus.cmd_valid     = 1'(vec[i].cv);
            bus.cmd_prio      = 2'(vec[i].prio);
            bus.cmd_len       = 4'(vec[i].len);
            bus.dat_valid     = 1'(vec[i].dv);
            bus.dat_data      = 512'(vec[i].d);
            bus.credit_return = 4'(vec[i].cr);
            #1;
            chk($sformatf("vec%0d_ready", i), 512'({bus.cmd_ready, bus.dat_ready}),
                512'({1'(vec[i].e_cr), 1'(vec[i].e_dr)}));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_flit_ctrl", i),
                512'({bus.flit_valid, bus.flit_vc_id, bus.flit_prio, bus.flit_pkt_id, bus.flit_tail}),
                512'({1'(vec[i].e_fv), 4'(vec[i].e_vc), 2'(vec[i].e_prio), 8'(vec[i].e_id), 1'(vec[i].e_tail)}));
            chk($sformatf("vec%0d_flit_data", i), bus.flit_data, 512'(vec[i].e_d));
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        bit ok, ok2;

        //          rst cv pr ln dv d            cr  ecr edr efv e_d          evc eid etl epr
        vec[0]  = '{1, 1, 2, 3, 0, 0,            0,  1,  0,  0,  0,           0,  0,  0,  0};
        vec[1]  = '{0, 0, 3, 0, 1, 32'hD0D00000, 0,  0,  1,  1,  32'hD0D00000,4,  0,  0,  2};
        vec[2]  = '{0, 0, 3, 0, 1, 32'hD0D00001, 0,  0,  1,  1,  32'hD0D00001,4,  0,  0,  2};
        vec[3]  = '{0, 0, 3, 0, 1, 32'hD0D00002, 0,  0,  1,  1,  32'hD0D00002,4,  0,  0,  2};
        vec[4]  = '{0, 0, 3, 0, 1, 32'hD0D00003, 0,  0,  1,  1,  32'hD0D00003,4,  0,  1,  2};
        vec[5]  = '{0, 0, 0, 0, 0, 0,            0,  1,  0,  0,  32'hD0D00003,4,  0,  1,  2};
        vec[6]  = '{0, 0, 0, 0, 1, 32'h00000BAD, 0,  1,  0,  0,  32'hD0D00003,4,  0,  1,  2};
        vec[7]  = '{1, 1, 1, 0, 0, 0,            0,  1,  0,  0,  0,           0,  0,  0,  0};
        vec[8]  = '{0, 0, 0, 0, 1, 32'hAAAA0000, 0,  0,  1,  1,  32'hAAAA0000,2,  0,  1,  1};
        vec[9]  = '{0, 1, 1, 1, 0, 0,            0,  1,  0,  0,  32'hAAAA0000,2,  0,  1,  1};
        vec[10] = '{0, 0, 0, 0, 1, 32'hBBBB0000, 0,  0,  1,  1,  32'hBBBB0000,2,  1,  0,  1};
        vec[11] = '{0, 0, 0, 0, 1, 32'hCCCC0000, 0,  0,  1,  1,  32'hCCCC0000,2,  1,  1,  1};
        vec[12] = '{0, 0, 0, 0, 0, 0,            0,  1,  0,  0,  32'hCCCC0000,2,  1,  1,  1};

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_flit_ctrl", 512'({bus.flit_valid, bus.flit_vc_id, bus.flit_prio, bus.flit_pkt_id, bus.flit_tail}), 512'(0));
        chk("reset_flit_data", bus.flit_data, 512'(0));
        chk("reset_status", 512'({busy, err_credit, bus.cmd_ready, bus.dat_ready}), 512'(4'b0010));
        chk("reset_credits", 512'(bus.credit_cnt), 512'({4{5'd16}}));

        // 4-beat packet on VC2, then IDLE holds
        run_vectors(0, 6);
        chk("pkt4_credit2", 512'(cred(2)), 512'(12));
        chk("pkt4_credit0", 512'(cred(0)), 512'(16));

        // back-to-back len=0 then len=1
        run_vectors(7, 12);

        // Credit starvation on VC0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_cmd(0, 0, ok);
            do_beat(32'h100 + i, 4'b0000, ok2);
            chk($sformatf("fill%0d_hs", i), 512'({ok, ok2}), 512'(2'b11));
        end
        chk("starve_credit0", 512'(cred(0)), 512'(0));
        do_cmd(0, 0, ok);
        chk("starve_cmd_hs", 512'(ok), 512'(1));
        chk("starve_busy", 512'(busy), 512'(1));
        @(negedge clk);
        bus.dat_valid = 1'b1;
        bus.dat_data  = 512'(32'h55);
        for (int n = 0; n < 3; n++) begin
            #1;
            chk($sformatf("starve_ready%0d", n), 512'(bus.dat_ready), 512'(0));
            @(negedge clk);
        end
        bus.credit_return = 4'b0001;
        #1;
        chk("ret_ready_same_cycle", 512'(bus.dat_ready), 512'(0));
        @(posedge clk);
        #1;
        bus.credit_return = '0;
        chk("ret_ready_next_cycle", 512'(bus.dat_ready), 512'(1));
        chk("ret_credit0", 512'(cred(0)), 512'(1));
        @(posedge clk);
        #1;
        bus.dat_valid = 1'b0;
        chk("starve_flit_ctrl", 512'({bus.flit_valid, bus.flit_vc_id, bus.flit_pkt_id, bus.flit_tail}),
            512'({1'b1, 4'b0001, 8'd16, 1'b1}));
        chk("starve_flit_data", bus.flit_data, 512'(32'h55));
        chk("starve_credit0_after", 512'(cred(0)), 512'(0));

        // Simultaneous send/return and overflow on idle VC
        do_reset();
        chk("err_clear", 512'(err_credit), 512'(0));
        for (int i = 0; i < 11; i++) begin
            do_cmd(1, 0, ok);
            do_beat(32'h200 + i, 4'b0000, ok2);
        end
        chk("vc1_credit5", 512'(cred(1)), 512'(5));
        do_cmd(1, 0, ok);
        do_beat(32'h77, 4'b0010, ok2);
        chk("simul_hs", 512'({ok, ok2, bus.flit_valid}), 512'(3'b111));
        chk("simul_credit1", 512'(cred(1)), 512'(5));
        @(negedge clk);
        bus.credit_return = 4'b1000;
        @(posedge clk);
        #1;
        bus.credit_return = '0;
        chk("ovf_credit3", 512'(cred(3)), 512'(16));
        chk("ovf_err", 512'(err_credit), 512'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_err_sticky", 512'(err_credit), 512'(1));

        // pkt_id wrap over 257 packets; returns keep credits topped up
        do_reset();
        for (int i = 0; i < 257; i++) begin
            do_cmd(i % 4, 0, ok);
            do_beat(i, 4'(1 << (i % 4)), ok2);
            chk($sformatf("wrap%0d", i), 512'({ok, ok2, bus.flit_valid, bus.flit_pkt_id}),
                512'({3'b111, 8'(i % 256)}));
        end
        chk("wrap_credits", 512'(bus.credit_cnt), 512'({4{5'd16}}));

        // Reset in the middle of a len=7 packet
        do_reset();
        do_cmd(0, 7, ok);
        for (int i = 0; i < 3; i++) do_beat(32'h300 + i, 4'b0000, ok2);
        chk("mid_busy", 512'({busy, bus.flit_valid}), 512'(2'b11));
        chk("mid_credit0", 512'(cred(0)), 512'(13));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flit_ctrl", 512'({bus.flit_valid, bus.flit_vc_id, bus.flit_prio, bus.flit_pkt_id, bus.flit_tail}), 512'(0));
        chk("mid_rst_flit_data", bus.flit_data, 512'(0));
        chk("mid_rst_status", 512'({busy, err_credit}), 512'(0));
        chk("mid_rst_credits", 512'(bus.credit_cnt), 512'({4{5'd16}}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_no_stale_flit", 512'({bus.flit_valid, bus.flit_tail}), 512'(0));
        do_cmd(3, 0, ok);
        do_beat(32'hEE, 4'b0000, ok2);
        chk("mid_restart_ctrl", 512'({bus.flit_valid, bus.flit_vc_id, bus.flit_prio, bus.flit_pkt_id, bus.flit_tail}),
            512'({1'b1, 4'b1000, 2'd3, 8'd0, 1'b1}));
        chk("mid_restart_data", bus.flit_data, 512'(32'hEE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
